// File: rtl/mem_access_stage.sv
// Stage-4 memory access: registers ALU/write-back control and drives a variable-latency req/ack memory port.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-cycle limit with squashed result and sticky err_timeout.
module mem_access_stage #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int REG_AW      = 3,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_in,
   input  logic              write_reg_in,
   input  logic [REG_AW-1:0] reg_addr_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic              mem_write_in,
   input  logic              mem_read_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   output logic              write_reg_out,
   output logic [REG_AW-1:0] reg_addr_out,
   output logic              load_sel,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] load_data,
   output logic              err_timeout
);
   typedef enum logic {IDLE, WAIT} stateT;

   stateT             state;
   logic [DATA_W-1:0] latAlu;
   logic              latWriteReg;
   logic              latRead;
   logic [REG_AW-1:0] latRegAddr;
   logic              memOp;
   logic              isLoad;

   assign memOp    = mem_read_in | mem_write_in;
   // Read and write together is treated as a store.
   assign isLoad   = latRead & ~mem_we;
   assign in_ready = (state == IDLE);
   assign mem_req  = (state == WAIT);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] waitCnt;
   logic             limitHit;
   assign limitHit = (waitCnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         out_valid     <= 1'b0;
         write_reg_out <= 1'b0;
         reg_addr_out  <= '0;
         load_sel      <= 1'b0;
         alu_out       <= '0;
         load_data     <= '0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         latAlu        <= '0;
         latWriteReg   <= 1'b0;
         latRead       <= 1'b0;
         latRegAddr    <= '0;
`ifdef MEM_TIMEOUT_EN
         waitCnt       <= '0;
         err_timeout   <= 1'b0;
`endif
      end else begin
         out_valid     <= 1'b0;
         write_reg_out <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (memOp) begin
                     state       <= WAIT;
                     mem_we      <= mem_write_in;
                     mem_addr    <= addr_in;
                     mem_wdata   <= store_data_in;
                     latAlu      <= alu_in;
                     latWriteReg <= write_reg_in;
                     latRead     <= mem_read_in;
                     latRegAddr  <= reg_addr_in;
`ifdef MEM_TIMEOUT_EN
                     waitCnt     <= '0;
`endif
                  end else begin
                     out_valid     <= 1'b1;
                     write_reg_out <= write_reg_in;
                     reg_addr_out  <= reg_addr_in;
                     alu_out       <= alu_in;
                     load_sel      <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  state         <= IDLE;
                  out_valid     <= 1'b1;
                  write_reg_out <= latWriteReg;
                  reg_addr_out  <= latRegAddr;
                  alu_out       <= latAlu;
                  load_sel      <= isLoad;
                  if (isLoad) load_data <= mem_rdata;
               end
`ifdef MEM_TIMEOUT_EN
               // Ack on the limit cycle takes priority over the abort.
               else if (limitHit) begin
                  state       <= IDLE;
                  out_valid   <= 1'b1;
                  load_sel    <= 1'b0;
                  err_timeout <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed plan items plus randomized ops against a transaction-level model.
// Honours MEM_TIMEOUT_EN when defined for the whole build.
module tb_mem_access_stage;
   localparam int DW = 16;
   localparam int AW = 16;
   localparam int RW = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] alu_in = '0;
   logic          write_reg_in = 1'b0;
   logic [RW-1:0] reg_addr_in = '0;
   logic [AW-1:0] addr_in = '0;
   logic [DW-1:0] store_data_in = '0;
   logic          mem_write_in = 1'b0;
   logic          mem_read_in = 1'b0;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          out_valid;
   logic          write_reg_out;
   logic [RW-1:0] reg_addr_out;
   logic          load_sel;
   logic [DW-1:0] alu_out;
   logic [DW-1:0] load_data;
   logic          err_timeout;

   always #5 clock = ~clock;

   mem_access_stage #(
      .DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .TIMEOUT_CYC(4)
   ) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_in(alu_in), .write_reg_in(write_reg_in), .reg_addr_in(reg_addr_in),
      .addr_in(addr_in), .store_data_in(store_data_in),
      .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .write_reg_out(write_reg_out), .reg_addr_out(reg_addr_out),
      .load_sel(load_sel), .alu_out(alu_out), .load_data(load_data), .err_timeout(err_timeout)
   );

   int unsigned   nChecks = 0;
   int unsigned   nFails  = 0;
   // Model of the architecturally visible held values
   logic [DW-1:0] expAlu  = '0;
   logic [DW-1:0] expLoad = '0;
   logic [RW-1:0] expReg  = '0;
   logic          expErr  = 1'b0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic garbageInputs(input logic valid);
      in_valid      = valid;
      alu_in        = DW'($urandom);
      write_reg_in  = 1'($urandom);
      reg_addr_in   = RW'($urandom);
      addr_in       = AW'($urandom);
      store_data_in = DW'($urandom);
      mem_write_in  = 1'($urandom);
      mem_read_in   = 1'($urandom);
      mem_rdata     = DW'($urandom);
   endtask

   task automatic checkOut(input string tag, input logic v, input logic wr, input logic ls);
      checkVal({tag, " out_valid"}, out_valid, v);
      checkVal({tag, " write_reg_out"}, write_reg_out, v & wr);
      checkVal({tag, " reg_addr_out"}, reg_addr_out, expReg);
      checkVal({tag, " alu_out"}, alu_out, expAlu);
      checkVal({tag, " load_data"}, load_data, expLoad);
      checkVal({tag, " err_timeout"}, err_timeout, expErr);
      if (v) checkVal({tag, " load_sel"}, load_sel, ls);
   endtask

   task automatic bubble(input string tag);
      garbageInputs(1'b0);
      mem_ack = 1'($urandom);
      tick();
      mem_ack = 1'b0;
      checkOut({tag, " bubble"}, 1'b0, 1'b0, 1'b0);
   endtask

   // Presents one instruction in the current (idle) cycle and follows it to its result cycle.
   task automatic runOp(input string tag, input logic rd, input logic wr, input logic wrReg,
                        input logic [RW-1:0] ra, input logic [DW-1:0] alu, input logic [AW-1:0] addr,
                        input logic [DW-1:0] sdata, input logic [DW-1:0] rdata, input int unsigned ackDelay);
      checkVal({tag, " in_ready before"}, in_ready, 1'b1);
      in_valid = 1'b1; alu_in = alu; write_reg_in = wrReg; reg_addr_in = ra;
      addr_in = addr; store_data_in = sdata; mem_read_in = rd; mem_write_in = wr;
      mem_ack = 1'($urandom); mem_rdata = DW'($urandom);
      tick();
      if (!(rd || wr)) begin
         expAlu = alu; expReg = ra;
         in_valid = 1'b0; mem_ack = 1'b0;
         checkOut({tag, " alu"}, 1'b1, wrReg, 1'b0);
         return;
      end
      for (int unsigned k = 1; k <= ackDelay; k++) begin
         checkVal({tag, " mem_req"}, mem_req, 1'b1);
         checkVal({tag, " mem_we"}, mem_we, wr);
         checkVal({tag, " mem_addr"}, mem_addr, addr);
         checkVal({tag, " mem_wdata"}, mem_wdata, sdata);
         checkVal({tag, " in_ready wait"}, in_ready, 1'b0);
         checkVal({tag, " out_valid wait"}, out_valid, 1'b0);
         checkVal({tag, " write_reg_out wait"}, write_reg_out, 1'b0);
         garbageInputs(1'($urandom));
         mem_ack = (k == ackDelay);
         if (k == ackDelay) mem_rdata = rdata;
         tick();
      end
      in_valid = 1'b0; mem_ack = 1'b0;
      expAlu = alu; expReg = ra;
      if (rd && !wr) expLoad = rdata;
      checkOut({tag, " done"}, 1'b1, wrReg, rd && !wr);
      checkVal({tag, " in_ready after"}, in_ready, 1'b1);
      checkVal({tag, " mem_req after"}, mem_req, 1'b0);
   endtask

   initial begin
      // Reset held for two cycles
      garbageInputs(1'b0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checkOut("reset", 1'b0, 1'b0, 1'b0);
      checkVal("reset load_sel", load_sel, 1'b0);
      checkVal("reset in_ready", in_ready, 1'b1);
      checkVal("reset mem_req", mem_req, 1'b0);
      checkVal("reset mem_we", mem_we, 1'b0);
      checkVal("reset mem_addr", mem_addr, 0);
      checkVal("reset mem_wdata", mem_wdata, 0);

      runOp("nonmem", 1'b0, 1'b0, 1'b1, 3'd5, 16'h1234, 16'h0, 16'h0, 16'h0, 1);
      bubble("nonmem");
      runOp("load", 1'b1, 1'b0, 1'b1, 3'd3, 16'h0077, 16'h0040, 16'h1111, 16'hBEEF, 3);
      bubble("load");
      runOp("store", 1'b0, 1'b1, 1'b0, 3'd2, 16'h0055, 16'h0100, 16'hA5A5, 16'h2222, 1);
      runOp("rdwr", 1'b1, 1'b1, 1'b1, 3'd6, 16'h0099, 16'h0200, 16'h5A5A, 16'h3333, 1);
      bubble("rdwr");

      // Reset in the second WAIT cycle, then a stray ack
      in_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; addr_in = 16'h0300;
      alu_in = 16'h4444; write_reg_in = 1'b1; reg_addr_in = 3'd1;
      tick();
      in_valid = 1'b0;
      checkVal("rstwait mem_req c1", mem_req, 1'b1);
      tick();
      checkVal("rstwait mem_req c2", mem_req, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expAlu = '0; expLoad = '0; expReg = '0; expErr = 1'b0;
      checkVal("rstwait mem_req", mem_req, 1'b0);
      checkVal("rstwait in_ready", in_ready, 1'b1);
      checkOut("rstwait", 1'b0, 1'b0, 1'b0);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      mem_ack = 1'b0;
      checkOut("stray ack", 1'b0, 1'b0, 1'b0);
      checkVal("stray ack mem_req", mem_req, 1'b0);

`ifdef MEM_TIMEOUT_EN
      in_valid = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; addr_in = 16'h0500;
      alu_in = 16'h6666; write_reg_in = 1'b1; reg_addr_in = 3'd4;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkVal("timeout mem_req", mem_req, 1'b1);
         tick();
      end
      expErr = 1'b1;
      checkVal("timeout out_valid", out_valid, 1'b1);
      checkVal("timeout write_reg_out", write_reg_out, 1'b0);
      checkVal("timeout load_sel", load_sel, 1'b0);
      checkVal("timeout err_timeout", err_timeout, 1'b1);
      checkVal("timeout mem_req drop", mem_req, 1'b0);
      checkVal("timeout in_ready", in_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkVal("timeout err sticky", err_timeout, 1'b1);
         checkVal("timeout single pulse", out_valid, 1'b0);
      end
      runOp("post timeout", 1'b1, 1'b0, 1'b1, 3'd7, 16'h7777, 16'h0600, 16'h0, 16'hCAFE, 4);
`else
      runOp("long wait", 1'b1, 1'b0, 1'b1, 3'd4, 16'h6666, 16'h0500, 16'h0, 16'hF00D, 110);
`endif
      bubble("directed end");

      for (int n = 0; n < 80; n++) begin
         int unsigned kind;
         kind = $urandom_range(0, 3);
         runOp("rand", kind == 1 || kind == 3, kind >= 2, 1'($urandom), RW'($urandom),
               DW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
               $urandom_range(1, 4));
         if ($urandom_range(0, 2) == 0) bubble("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
